// File: rtl/isdu_ctrl.sv
// LC-3 instruction sequencing and decode unit: Moore FSM driving datapath loads, gates, muxes and memory strobes.
// Define ISDU_JSR_EN to add JSR/JSRR sequencing (S04/S20/S21) and the IR_11 input.
module isdu_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
`ifdef ISDU_JSR_EN
    input  logic       IR_11,
`endif
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_RD,
    output logic       Mem_WR
);

    localparam logic [4:0] ST_HALTED = 5'd0;
    localparam logic [4:0] ST_S18    = 5'd1;
    localparam logic [4:0] ST_S33    = 5'd2;
    localparam logic [4:0] ST_S35    = 5'd3;
    localparam logic [4:0] ST_S32    = 5'd4;
    localparam logic [4:0] ST_S01    = 5'd5;
    localparam logic [4:0] ST_S05    = 5'd6;
    localparam logic [4:0] ST_S09    = 5'd7;
    localparam logic [4:0] ST_S00    = 5'd8;
    localparam logic [4:0] ST_S22    = 5'd9;
    localparam logic [4:0] ST_S12    = 5'd10;
    localparam logic [4:0] ST_S06    = 5'd11;
    localparam logic [4:0] ST_S07    = 5'd12;
    localparam logic [4:0] ST_S25    = 5'd13;
    localparam logic [4:0] ST_S27    = 5'd14;
    localparam logic [4:0] ST_S23    = 5'd15;
    localparam logic [4:0] ST_S16    = 5'd16;
    localparam logic [4:0] ST_PAUSE1 = 5'd17;
    localparam logic [4:0] ST_PAUSE2 = 5'd18;
`ifdef ISDU_JSR_EN
    localparam logic [4:0] ST_S04    = 5'd19;
    localparam logic [4:0] ST_S20    = 5'd20;
    localparam logic [4:0] ST_S21    = 5'd21;
`endif

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [4:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       in_wait_s;
    logic       wait_done_s;

    assign in_wait_s   = (state_q == ST_S33) || (state_q == ST_S25) || (state_q == ST_S16);
    assign wait_done_s = (cnt_q == WAIT_LAST);

    // Next-state selection; memory states hold until the wait counter expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALTED: begin
                if (Run) state_d = ST_S18;
                else     state_d = ST_HALTED;
            end
            ST_S18: state_d = ST_S33;
            ST_S33: begin
                if (wait_done_s) state_d = ST_S35;
                else             state_d = ST_S33;
            end
            ST_S35: state_d = ST_S32;
            ST_S32: begin
                case (Opcode)
                    4'b0001: state_d = ST_S01;
                    4'b0101: state_d = ST_S05;
                    4'b1001: state_d = ST_S09;
                    4'b0000: state_d = ST_S00;
                    4'b1100: state_d = ST_S12;
                    4'b0110: state_d = ST_S06;
                    4'b0111: state_d = ST_S07;
                    4'b1101: state_d = ST_PAUSE1;
`ifdef ISDU_JSR_EN
                    4'b0100: state_d = ST_S04;
`endif
                    default: state_d = ST_S18;
                endcase
            end
            ST_S01, ST_S05, ST_S09, ST_S22, ST_S12, ST_S27: state_d = ST_S18;
            // BEN was loaded on the S32 edge, so it is only trusted here.
            ST_S00: begin
                if (BEN) state_d = ST_S22;
                else     state_d = ST_S18;
            end
            ST_S06: state_d = ST_S25;
            ST_S07: state_d = ST_S23;
            ST_S25: begin
                if (wait_done_s) state_d = ST_S27;
                else             state_d = ST_S25;
            end
            ST_S23: state_d = ST_S16;
            ST_S16: begin
                if (wait_done_s) state_d = ST_S18;
                else             state_d = ST_S16;
            end
            ST_PAUSE1: begin
                if (Continue) state_d = ST_PAUSE2;
                else          state_d = ST_PAUSE1;
            end
            ST_PAUSE2: begin
                if (!Continue) state_d = ST_S18;
                else           state_d = ST_PAUSE2;
            end
`ifdef ISDU_JSR_EN
            ST_S04: begin
                if (IR_11) state_d = ST_S21;
                else       state_d = ST_S20;
            end
            ST_S20, ST_S21: state_d = ST_S18;
`endif
            default: state_d = ST_HALTED;
        endcase
    end

    // Wait counter runs only while a memory state is held, so every entry starts from zero.
    always_comb begin
        if (in_wait_s && (state_d == state_q)) cnt_d = cnt_q + 4'd1;
        else                                    cnt_d = 4'd0;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_HALTED;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode; IR_5 only steers SR2MUX in the ADD/AND states.
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_RD     = 1'b0;
        Mem_WR     = 1'b0;
        case (state_q)
            ST_S18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = 2'b00;
                LD_PC  = 1'b1;
            end
            ST_S33, ST_S25: begin
                Mem_RD = 1'b1;
                LD_MDR = 1'b1;
            end
            ST_S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            ST_S32: LD_BEN = 1'b1;
            ST_S01, ST_S05: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR_5;
                ALUK    = (state_q == ST_S05) ? 2'b01 : 2'b00;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            ST_S09: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b10;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            ST_S22: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            ST_S12: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b00;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            ST_S06, ST_S07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            ST_S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            ST_S23: begin
                SR1MUX  = 1'b0;
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            ST_S16: Mem_WR = 1'b1;
            ST_PAUSE1: LD_LED = 1'b1;
`ifdef ISDU_JSR_EN
            ST_S04: begin
                DRMUX  = 1'b1;
                GatePC = 1'b1;
                LD_REG = 1'b1;
            end
            ST_S21: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            ST_S20: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b00;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
`endif
            default: begin
                LD_MAR = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_isdu_ctrl.sv
// Self-checking bench for isdu_ctrl: two instances (WAIT_CYCLES 2 and 3), a latency table and a
// per-instruction control-word sequence model driven with random instructions.
module tb_isdu_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [1:0]  rst;
    logic [1:0]  run;
    logic [1:0]  cont;
    logic [1:0]  ir5;
    logic [1:0]  ben;
    logic [1:0]  ir11;
    logic [3:0]  opc [2];
    logic [23:0] ow  [2];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic drmux, sr1mux, sr2mux, addr1mux, mem_rd, mem_wr;
        logic [1:0] pcmux, addr2mux, aluk;

        isdu_ctrl #(.WAIT_CYCLES(g + 2)) u_dut (
            .Clk(Clk), .Reset(rst[g]), .Run(run[g]), .Continue(cont[g]),
            .Opcode(opc[g]), .IR_5(ir5[g]),
`ifdef ISDU_JSR_EN
            .IR_11(ir11[g]),
`endif
            .BEN(ben[g]),
            .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
            .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
            .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
            .PCMUX(pcmux), .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux),
            .ADDR1MUX(addr1mux), .ADDR2MUX(addr2mux), .ALUK(aluk),
            .Mem_RD(mem_rd), .Mem_WR(mem_wr)
        );

        assign ow[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                        gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, drmux, sr1mux,
                        sr2mux, addr1mux, addr2mux, aluk, mem_rd, mem_wr};
    end

    // Control-word bit patterns, in the packing order used for ow above.
    localparam logic [23:0] C_LD_MAR    = 24'h800000;
    localparam logic [23:0] C_LD_MDR    = 24'h400000;
    localparam logic [23:0] C_LD_IR     = 24'h200000;
    localparam logic [23:0] C_LD_BEN    = 24'h100000;
    localparam logic [23:0] C_LD_CC     = 24'h080000;
    localparam logic [23:0] C_LD_REG    = 24'h040000;
    localparam logic [23:0] C_LD_PC     = 24'h020000;
    localparam logic [23:0] C_LD_LED    = 24'h010000;
    localparam logic [23:0] C_GPC       = 24'h008000;
    localparam logic [23:0] C_GMDR      = 24'h004000;
    localparam logic [23:0] C_GALU      = 24'h002000;
    localparam logic [23:0] C_GMARMUX   = 24'h001000;
    localparam logic [23:0] C_PC_ADDER  = 24'h000800;
    localparam logic [23:0] C_DRMUX     = 24'h000200;
    localparam logic [23:0] C_SR1       = 24'h000100;
    localparam logic [23:0] C_SR2       = 24'h000080;
    localparam logic [23:0] C_ADDR1     = 24'h000040;
    localparam logic [23:0] C_OFF6      = 24'h000010;
    localparam logic [23:0] C_OFF9      = 24'h000020;
    localparam logic [23:0] C_OFF11     = 24'h000030;
    localparam logic [23:0] C_ALU_AND   = 24'h000004;
    localparam logic [23:0] C_ALU_NOT   = 24'h000008;
    localparam logic [23:0] C_ALU_PASS  = 24'h00000C;
    localparam logic [23:0] C_RD        = 24'h000002;
    localparam logic [23:0] C_WR        = 24'h000001;

    localparam logic [23:0] W_FETCH  = C_GPC | C_LD_MAR | C_LD_PC;
    localparam logic [23:0] W_MEMRD  = C_RD | C_LD_MDR;
    localparam logic [23:0] W_ADDR   = C_SR1 | C_ADDR1 | C_OFF6 | C_GMARMUX | C_LD_MAR;
    localparam logic [23:0] W_WRREG  = C_GALU | C_LD_REG | C_LD_CC;

    logic [23:0] exp_q [$];

    typedef struct {
        logic [3:0]  op;
        logic        i5;
        logic        b;
        int          len;
        logic [23:0] ex0;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Expected control words, one per cycle, from S18 up to (not including) the next S18.
    task automatic build(input int w, input logic [3:0] op, input logic i5, input logic b, input logic i11);
        exp_q.delete();
        exp_q.push_back(W_FETCH);
        repeat (w) exp_q.push_back(W_MEMRD);
        exp_q.push_back(C_GMDR | C_LD_IR);
        exp_q.push_back(C_LD_BEN);
        case (op)
            4'd1:  exp_q.push_back(C_SR1 | (i5 ? C_SR2 : 24'h0) | W_WRREG);
            4'd5:  exp_q.push_back(C_SR1 | (i5 ? C_SR2 : 24'h0) | C_ALU_AND | W_WRREG);
            4'd9:  exp_q.push_back(C_SR1 | C_ALU_NOT | W_WRREG);
            4'd0: begin
                exp_q.push_back(24'h0);
                if (b) exp_q.push_back(C_OFF9 | C_PC_ADDER | C_LD_PC);
            end
            4'd12: exp_q.push_back(C_SR1 | C_ADDR1 | C_PC_ADDER | C_LD_PC);
            4'd6: begin
                exp_q.push_back(W_ADDR);
                repeat (w) exp_q.push_back(W_MEMRD);
                exp_q.push_back(C_GMDR | C_LD_REG | C_LD_CC);
            end
            4'd7: begin
                exp_q.push_back(W_ADDR);
                exp_q.push_back(C_ALU_PASS | C_GALU | C_LD_MDR);
                repeat (w) exp_q.push_back(C_WR);
            end
`ifdef ISDU_JSR_EN
            4'd4: begin
                exp_q.push_back(C_DRMUX | C_GPC | C_LD_REG);
                exp_q.push_back(i11 ? (C_OFF11 | C_PC_ADDER | C_LD_PC)
                                    : (C_SR1 | C_ADDR1 | C_PC_ADDER | C_LD_PC));
            end
`endif
            default: exp_q.push_back(24'h0 & {24{i11}}) ;
        endcase
        // NOP/PAUSE have no execute word: drop the dummy entry pushed by the default branch
        if (!(op inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12}))
`ifdef ISDU_JSR_EN
            if (op != 4'd4)
`endif
                void'(exp_q.pop_back());
    endtask

    // Runs one instruction on DUT d starting at posedge+1 of S18; ends at posedge+1 of the next S18.
    task automatic run_instr(input int d, input int w, input logic [3:0] op, input logic i5,
                             input logic b, input int p1, input int p2);
        logic i11;
        i11      = 1'($urandom);
        ir11[d]  = i11;
        ir5[d]   = i5;
        ben[d]   = ~b;
        cont[d]  = 1'b0;
        opc[d]   = 4'($urandom);
        build(w, op, i5, b, i11);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == w + 2) opc[d] = op;
            if (k == w + 3) ben[d] = b;
            @(negedge Clk);
            check($sformatf("dut%0d op%h cyc%0d", d, op, k), ow[d], exp_q[k]);
            step();
        end
        if (op == 4'd13) begin
            for (int i = 0; i < p1; i++) begin
                @(negedge Clk); check("pause1 wait", ow[d], C_LD_LED); step();
            end
            cont[d] = 1'b1;
            @(negedge Clk); check("pause1 cont", ow[d], C_LD_LED); step();
            for (int i = 0; i < p2; i++) begin
                @(negedge Clk); check("pause2 hold", ow[d], 24'h0); step();
            end
            cont[d] = 1'b0;
            @(negedge Clk); check("pause2 release", ow[d], 24'h0); step();
        end
    endtask

    // From HALTED at posedge+1: pulse Run so the next state is S18.
    task automatic start(input int d);
        run[d] = 1'b1;
        @(negedge Clk);
        check($sformatf("dut%0d halted before run", d), ow[d], 24'h0);
        step();
        run[d] = 1'b0;
    endtask

    initial begin
        int          len;
        logic [23:0] first;

        tbl[0]  = '{4'd1,  1'b1, 1'b0, 6, C_SR1 | C_SR2 | W_WRREG};
        tbl[1]  = '{4'd1,  1'b0, 1'b0, 6, C_SR1 | W_WRREG};
        tbl[2]  = '{4'd5,  1'b1, 1'b0, 6, C_SR1 | C_SR2 | C_ALU_AND | W_WRREG};
        tbl[3]  = '{4'd9,  1'b0, 1'b0, 6, C_SR1 | C_ALU_NOT | W_WRREG};
        tbl[4]  = '{4'd0,  1'b0, 1'b1, 7, 24'h0};
        tbl[5]  = '{4'd0,  1'b0, 1'b0, 6, 24'h0};
        tbl[6]  = '{4'd12, 1'b0, 1'b0, 6, C_SR1 | C_ADDR1 | C_PC_ADDER | C_LD_PC};
        tbl[7]  = '{4'd6,  1'b0, 1'b0, 9, W_ADDR};
        tbl[8]  = '{4'd7,  1'b0, 1'b0, 9, W_ADDR};
`ifdef ISDU_JSR_EN
        tbl[9]  = '{4'd4,  1'b0, 1'b0, 7, C_DRMUX | C_GPC | C_LD_REG};
`else
        tbl[9]  = '{4'd4,  1'b0, 1'b0, 5, W_FETCH};
`endif
        tbl[10] = '{4'd15, 1'b0, 1'b0, 5, W_FETCH};
        tbl[11] = '{4'd2,  1'b0, 1'b0, 5, W_FETCH};

        rst  = 2'b11;
        run  = 2'b00;
        cont = 2'b00;
        ir5  = 2'b00;
        ben  = 2'b00;
        ir11 = 2'b00;
        opc[0] = 4'd0;
        opc[1] = 4'd0;
        step();
        step();
        rst = 2'b00;
        @(negedge Clk);
        check("reset dut0", ow[0], 24'h0);
        check("reset dut1", ow[1], 24'h0);
        step();
        @(negedge Clk);
        check("halted idle dut0", ow[0], 24'h0);
        step();

        // Latency / first execute word table on the WAIT_CYCLES=2 instance.
        start(0);
        for (int t = 0; t < 12; t++) begin
            opc[0] = tbl[t].op;
            ir5[0] = tbl[t].i5;
            ben[0] = tbl[t].b;
            ir11[0] = 1'b0;
            len    = 0;
            first  = 24'h0;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (k == 5) first = ow[0];
                if (ow[0] == W_FETCH) begin
                    len = k;
                    break;
                end
            end
            check($sformatf("tbl%0d length", t), 24'(len), 24'(tbl[t].len));
            check($sformatf("tbl%0d exec word", t), first, tbl[t].ex0);
        end

        // Hand sequences: pause stall and a mid-access reset.
        run_instr(0, 2, 4'd13, 1'b0, 1'b0, 3, 4);
        run_instr(0, 2, 4'd0, 1'b0, 1'b1, 0, 0);
        run[0] = 1'b0;
        opc[0] = 4'd1;
        @(negedge Clk); check("pre-reset S18", ow[0], W_FETCH); step();
        @(negedge Clk); check("S33 wait1", ow[0], W_MEMRD); step();
        rst[0] = 1'b1;
        @(negedge Clk); check("S33 wait2", ow[0], W_MEMRD); step();
        rst[0] = 1'b0;
        @(negedge Clk); check("reset mid-access", ow[0], 24'h0); step();
        @(negedge Clk); check("halted after reset", ow[0], 24'h0); step();
        start(0);

        // Random instructions against the sequence model, Run toggled freely (must be ignored).
        for (int i = 0; i < 150; i++) begin
            run[0] = 1'($urandom);
            run_instr(0, 2, 4'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // WAIT_CYCLES=3 instance: STR first, then random traffic.
        start(1);
        run_instr(1, 3, 4'd7, 1'b0, 1'b0, 0, 0);
        run_instr(1, 3, 4'd6, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            run[1] = 1'($urandom);
            run_instr(1, 3, 4'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
